// File: rtl/mac_chain_pkg.sv
// mac_chain_pkg: shared types and sign-magnitude arithmetic for the mac_chain column.
// Optional build macro: MAC_CHAIN_SATURATE_EN (clamp overflowing sums instead of wrapping).
// The arithmetic helpers work on a wide fixed container and take the real
// operand widths as arguments, so one set of functions serves every PE width.
package mac_chain_pkg;

   localparam int SM_MAX_W = 128;

   typedef enum logic {
      LOAD  = 1'b0,
      READY = 1'b1
   } load_state_t;

   typedef logic [SM_MAX_W-1:0] sm_word_t;

   typedef struct packed {
      logic     sign;
      sm_word_t mag;
   } sm_t;

   // Low 'bits' bits set.
   function automatic sm_word_t sm_mask(input int bits);
      sm_word_t one;
      one = sm_word_t'(1);
      return (one << bits) - one;
   endfunction

   // Split a 'bits'-wide sign-magnitude word; -0 becomes +0.
   function automatic sm_t sm_unpack(input sm_word_t word, input int bits);
      sm_t r;
      r.mag  = word & sm_mask(bits - 1);
      r.sign = |(word & (sm_word_t'(1) << (bits - 1)));
      if (r.mag == '0) begin
         r.sign = 1'b0;
      end
      return r;
   endfunction

   // Rebuild a 'bits'-wide sign-magnitude word, sign in bit bits-1.
   function automatic sm_word_t sm_pack(input sm_t v, input int bits);
      sm_word_t w;
      w = v.mag & sm_mask(bits - 1);
      if (v.sign) begin
         w = w | (sm_word_t'(1) << (bits - 1));
      end
      return w;
   endfunction

   // Sign-magnitude product; a zero product is always +0.
   function automatic sm_t sm_mul(input sm_word_t a, input int a_bits,
                                  input sm_word_t w, input int w_bits);
      sm_t ua;
      sm_t uw;
      sm_t r;
      ua     = sm_unpack(a, a_bits);
      uw     = sm_unpack(w, w_bits);
      r.mag  = ua.mag * uw.mag;
      r.sign = ua.sign ^ uw.sign;
      if (r.mag == '0) begin
         r.sign = 1'b0;
      end
      return r;
   endfunction

`ifdef MAC_CHAIN_SATURATE_EN
   // Clamp a magnitude that no longer fits in mag_bits to the largest value.
   function automatic sm_word_t sm_saturate(input sm_word_t sum, input int mag_bits);
      if ((sum & ~sm_mask(mag_bits)) != '0) begin
         return sm_mask(mag_bits);
      end
      return sum;
   endfunction
`endif

   // Sign-magnitude add of two normalised operands with a mag_bits result.
   // Only like-signed adds can overflow; unlike signs subtract the smaller
   // magnitude from the larger and take the larger operand's sign.
   function automatic sm_t sm_add(input sm_t x, input sm_t y, input int mag_bits);
      sm_t      r;
      sm_word_t sum;
      r = '0;
      if (x.sign == y.sign) begin
         sum    = x.mag + y.mag;
`ifdef MAC_CHAIN_SATURATE_EN
         r.mag  = sm_saturate(sum, mag_bits);
`else
         r.mag  = sum & sm_mask(mag_bits);
`endif
         r.sign = x.sign;
      end else if (x.mag >= y.mag) begin
         r.mag  = x.mag - y.mag;
         r.sign = x.sign;
      end else begin
         r.mag  = y.mag - x.mag;
         r.sign = y.sign;
      end
      if (r.mag == '0) begin
         r.sign = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/mac_chain_pe.sv
// mac_pe: one weight-stationary sign-magnitude MAC processing element.
// Holds its weight, forwards its activation row and accumulates onto the
// incoming partial sum when its row is valid and the column is loaded.
module mac_pe
   import mac_chain_pkg::*;
#(
   parameter int A_BITWIDTH = 16,
   parameter int W_BITWIDTH = 8,
   parameter int P_BITWIDTH = 40
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  w_load,
   input  logic                  w_clear,
   input  logic [W_BITWIDTH-1:0] w_in,
   input  logic                  ready,
   input  logic                  a_en,
   input  logic [A_BITWIDTH-1:0] a_in,
   input  logic [P_BITWIDTH-1:0] chain_in,
   output logic [P_BITWIDTH-1:0] psum,
   output logic                  a_en_out,
   output logic [A_BITWIDTH-1:0] a_out
);

   logic [W_BITWIDTH-1:0] w_reg;
   logic [P_BITWIDTH-1:0] psum_next;

   // Combined multiply-accumulate of this row's activation onto the chain.
   assign psum_next = P_BITWIDTH'(sm_pack(
                         sm_add(sm_unpack(SM_MAX_W'(chain_in), P_BITWIDTH),
                                sm_mul(SM_MAX_W'(a_in), A_BITWIDTH,
                                       SM_MAX_W'(w_reg), W_BITWIDTH),
                                P_BITWIDTH - 1),
                         P_BITWIDTH));

   // Stationary weight: cleared on request, otherwise written once per load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_reg <= '0;
      end else if (w_clear) begin
         w_reg <= '0;
      end else if (w_load) begin
         w_reg <= w_in;
      end
   end

   // Activation row forwarded unconditionally to the next column.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_en_out <= 1'b0;
         a_out    <= '0;
      end else begin
         a_en_out <= a_en;
         a_out    <= a_in;
      end
   end

   // Partial sum only advances for a valid row once all weights are present.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         psum <= '0;
      end else if (a_en && ready) begin
         psum <= psum_next;
      end
   end

endmodule

// File: rtl/mac_chain.sv
// mac_chain: weight-stationary systolic column of NUM_PE sign-magnitude MACs.
// Optional build macro: MAC_CHAIN_SATURATE_EN (clamp overflowing sums instead of wrapping).
// Weights arrive on a daisy-chained port: the first NUM_PE words are kept
// here, later words are passed on to the next column.
module mac_chain
   import mac_chain_pkg::*;
#(
   parameter int NUM_PE     = 3,
   parameter int A_BITWIDTH = 16,
   parameter int W_BITWIDTH = 8,
   parameter int P_BITWIDTH = 40
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         W_en,
   input  logic [W_BITWIDTH-1:0]        W_in,
   input  logic                         W_clear,
   output logic                         W_loaded,
   output logic                         W_en_out,
   output logic [W_BITWIDTH-1:0]        W_out,
   input  logic [NUM_PE-1:0]            A_en,
   input  logic [NUM_PE*A_BITWIDTH-1:0] A_in,
   output logic [NUM_PE-1:0]            A_en_out,
   output logic [NUM_PE*A_BITWIDTH-1:0] A_out,
   input  logic [P_BITWIDTH-1:0]        P_in,
   output logic                         P_valid_out,
   output logic [P_BITWIDTH-1:0]        P_out
);

   localparam int CNT_W = $clog2(NUM_PE + 1);

   if (NUM_PE < 1) begin : g_bad_num_pe
      $error("mac_chain: NUM_PE must be at least 1");
   end
   if (P_BITWIDTH - 1 < A_BITWIDTH + W_BITWIDTH - 2) begin : g_bad_p_width
      $error("mac_chain: P_BITWIDTH too narrow for the product magnitude");
   end
   if (P_BITWIDTH > SM_MAX_W) begin : g_bad_max_width
      $error("mac_chain: P_BITWIDTH exceeds the arithmetic container width");
   end

   load_state_t           state_q;
   load_state_t           state_d;
   logic [CNT_W-1:0]      count_q;
   logic [CNT_W-1:0]      count_d;
   logic                  ready;
   logic                  load_accept;
   logic                  fwd_accept;
   logic [NUM_PE-1:0]     w_load;
   logic [P_BITWIDTH-1:0] chain [NUM_PE+1];

   assign ready       = (state_q == READY);
   assign load_accept = (state_q == LOAD) && W_en && !W_clear;
   assign fwd_accept  = ready && W_en && !W_clear;
   assign W_loaded    = ready;
   assign chain[0]    = P_in;
   assign P_out       = chain[NUM_PE];

   // Load FSM state and slot counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LOAD;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Next state: clear wins over any weight word, the last slot flips to READY.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (W_clear) begin
         state_d = LOAD;
         count_d = '0;
      end else if (load_accept) begin
         count_d = count_q + CNT_W'(1);
         if (count_q == CNT_W'(NUM_PE - 1)) begin
            state_d = READY;
         end
      end
   end

   // Weight words that arrive once this column is full go to the next column.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         W_en_out <= 1'b0;
         W_out    <= '0;
      end else begin
         W_en_out <= fwd_accept;
         if (fwd_accept) begin
            W_out <= W_in;
         end
      end
   end

   // A finished sum leaves the last PE one edge after its row is consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         P_valid_out <= 1'b0;
      end else begin
         P_valid_out <= A_en[NUM_PE-1] && ready;
      end
   end

   for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
      assign w_load[k] = load_accept && (count_q == CNT_W'(k));

      mac_pe #(
         .A_BITWIDTH (A_BITWIDTH),
         .W_BITWIDTH (W_BITWIDTH),
         .P_BITWIDTH (P_BITWIDTH)
      ) u_pe (
         .clk      (clk),
         .rst      (rst),
         .w_load   (w_load[k]),
         .w_clear  (W_clear),
         .w_in     (W_in),
         .ready    (ready),
         .a_en     (A_en[k]),
         .a_in     (A_in[k*A_BITWIDTH +: A_BITWIDTH]),
         .chain_in (chain[k]),
         .psum     (chain[k+1]),
         .a_en_out (A_en_out[k]),
         .a_out    (A_out[k*A_BITWIDTH +: A_BITWIDTH])
      );
   end

endmodule

// File: tb/tb_mac_chain.sv
// tb_mac_chain: directed checks of the mac_chain column (default size) plus a
// narrow two-PE instance that exercises the partial-sum overflow boundary.
module tb_mac_chain;

   logic        clk = 1'b0;
   logic        rst;

   logic        W_en;
   logic [7:0]  W_in;
   logic        W_clear;
   logic        W_loaded;
   logic        W_en_out;
   logic [7:0]  W_out;
   logic [2:0]  A_en;
   logic [47:0] A_in;
   logic [2:0]  A_en_out;
   logic [47:0] A_out;
   logic [39:0] P_in;
   logic        P_valid_out;
   logic [39:0] P_out;

   logic        W_en2;
   logic [7:0]  W_in2;
   logic        W_clear2;
   logic        W_loaded2;
   logic        W_en_out2;
   logic [7:0]  W_out2;
   logic [1:0]  A_en2;
   logic [31:0] A_in2;
   logic [1:0]  A_en_out2;
   logic [31:0] A_out2;
   logic [23:0] P_in2;
   logic        P_valid_out2;
   logic [23:0] P_out2;

   int tests = 0;
   int failures = 0;

   localparam logic [7:0]  W_P124 = 8'h7C;
   localparam logic [7:0]  W_N50  = 8'hB2;
   localparam logic [7:0]  W_N120 = 8'hF8;
   localparam logic [7:0]  W_P5   = 8'h05;
   localparam logic [15:0] A_P3513 = 16'h0DB9;
   localparam logic [15:0] A_N3513 = 16'h8DB9;
   localparam logic [15:0] A_P2019 = 16'h07E3;
   localparam logic [15:0] A_P2023 = 16'h07E7;
   localparam logic [39:0] P_N46   = 40'h80_0000_002E;
`ifdef MAC_CHAIN_SATURATE_EN
   localparam logic [23:0] SAT_EXP = 24'd8388607;
`else
   localparam logic [23:0] SAT_EXP = 24'd4160801;
`endif

   mac_chain #(
      .NUM_PE(3), .A_BITWIDTH(16), .W_BITWIDTH(8), .P_BITWIDTH(40)
   ) dut (
      .clk(clk), .rst(rst),
      .W_en(W_en), .W_in(W_in), .W_clear(W_clear),
      .W_loaded(W_loaded), .W_en_out(W_en_out), .W_out(W_out),
      .A_en(A_en), .A_in(A_in), .A_en_out(A_en_out), .A_out(A_out),
      .P_in(P_in), .P_valid_out(P_valid_out), .P_out(P_out)
   );

   mac_chain #(
      .NUM_PE(2), .A_BITWIDTH(16), .W_BITWIDTH(8), .P_BITWIDTH(24)
   ) dut_narrow (
      .clk(clk), .rst(rst),
      .W_en(W_en2), .W_in(W_in2), .W_clear(W_clear2),
      .W_loaded(W_loaded2), .W_en_out(W_en_out2), .W_out(W_out2),
      .A_en(A_en2), .A_in(A_in2), .A_en_out(A_en_out2), .A_out(A_out2),
      .P_in(P_in2), .P_valid_out(P_valid_out2), .P_out(P_out2)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      tests++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic loadWord(input logic [7:0] w);
      W_en = 1'b1;
      W_in = w;
      tick();
      W_en = 1'b0;
      W_in = '0;
   endtask

   // Three skewed rows of one vector; returns just after the edge on which
   // the finished sum appears at P_out.
   task automatic applyStimulus(input logic [15:0] a0, input logic [15:0] a1,
                                input logic [15:0] a2, input logic [39:0] p);
      A_en = 3'b001; A_in = {16'd0, 16'd0, a0}; P_in = p;
      tick();
      A_en = 3'b010; A_in = {16'd0, a1, 16'd0}; P_in = '0;
      tick();
      A_en = 3'b100; A_in = {a2, 16'd0, 16'd0};
      tick();
      A_en = '0; A_in = '0;
   endtask

   initial begin
      rst = 1'b1;
      W_en = 0; W_in = '0; W_clear = 0; A_en = '0; A_in = '0; P_in = '0;
      W_en2 = 0; W_in2 = '0; W_clear2 = 0; A_en2 = '0; A_in2 = '0; P_in2 = '0;
      tick();
      tick();
      checkOutput("reset_w_loaded", 64'(W_loaded), 64'd0);
      checkOutput("reset_p_out", 64'(P_out), 64'd0);
      checkOutput("reset_p_valid", 64'(P_valid_out), 64'd0);
      rst = 1'b0;
      tick();
      checkOutput("idle_w_en_out", 64'(W_en_out), 64'd0);
      checkOutput("idle_a_en_out", 64'(A_en_out), 64'd0);

      // Weight load and forwarding.
      loadWord(W_P124);
      loadWord(W_N50);
      checkOutput("load_partial_w_loaded", 64'(W_loaded), 64'd0);
      loadWord(W_N120);
      checkOutput("load_done_w_loaded", 64'(W_loaded), 64'd1);
      checkOutput("load_no_forward", 64'(W_en_out), 64'd0);
      loadWord(W_P5);
      checkOutput("fwd_w_en_out", 64'(W_en_out), 64'd1);
      checkOutput("fwd_w_out", 64'(W_out), 64'd5);
      tick();
      checkOutput("fwd_w_en_out_drop", 64'(W_en_out), 64'd0);

      // Main vector: 3513*124 - 2019*50 - 2023*120 = 91902.
      applyStimulus(A_P3513, A_P2019, A_P2023, 40'd0);
      checkOutput("main_p_valid", 64'(P_valid_out), 64'd1);
      checkOutput("main_p_out", 64'(P_out), 64'd91902);
      tick();
      checkOutput("main_p_valid_pulse", 64'(P_valid_out), 64'd0);

      // Back-to-back vectors, second one is +1,+1,+1 -> 124-50-120 = -46.
      A_en = 3'b001; A_in = {16'd0, 16'd0, A_P3513}; P_in = '0;
      tick();
      A_en = 3'b011; A_in = {16'd0, A_P2019, 16'd1};
      tick();
      A_en = 3'b110; A_in = {A_P2023, 16'd1, 16'd0};
      tick();
      checkOutput("b2b_first_valid", 64'(P_valid_out), 64'd1);
      checkOutput("b2b_first_p_out", 64'(P_out), 64'd91902);
      A_en = 3'b100; A_in = {16'd1, 16'd0, 16'd0};
      tick();
      checkOutput("b2b_second_valid", 64'(P_valid_out), 64'd1);
      checkOutput("b2b_second_p_out", 64'(P_out), 64'(P_N46));
      A_en = '0; A_in = '0;
      tick();
      checkOutput("b2b_valid_drop", 64'(P_valid_out), 64'd0);

      // Clear with a simultaneous weight word: word is dropped, reload needed.
      W_clear = 1'b1; W_en = 1'b1; W_in = W_P5;
      tick();
      W_clear = 1'b0; W_en = 1'b0; W_in = '0;
      checkOutput("clear_w_loaded", 64'(W_loaded), 64'd0);
      checkOutput("clear_no_forward", 64'(W_en_out), 64'd0);
      loadWord(W_P124);
      loadWord(W_N50);
      checkOutput("reload_partial_w_loaded", 64'(W_loaded), 64'd0);
      A_en = 3'b001; A_in = {16'd0, 16'd0, 16'h1234};
      tick();
      checkOutput("a_fwd_en", 64'(A_en_out), 64'd1);
      checkOutput("a_fwd_data", 64'(A_out), 64'h1234);
      A_en = '0; A_in = '0;
      applyStimulus(A_P3513, A_P2019, A_P2023, 40'd0);
      checkOutput("load_state_no_valid", 64'(P_valid_out), 64'd0);
      checkOutput("load_state_psum_hold", 64'(P_out), 64'(P_N46));
      loadWord(W_N120);
      checkOutput("reload_w_loaded", 64'(W_loaded), 64'd1);

      // Cancellation to zero must come out as +0.
      applyStimulus(A_N3513, 16'd0, 16'd0, 40'd435612);
      checkOutput("cancel_valid", 64'(P_valid_out), 64'd1);
      checkOutput("cancel_p_out", 64'(P_out), 64'd0);
      tick();
      applyStimulus(A_P3513, A_P2019, A_P2023, 40'd0);
      checkOutput("reload_main_p_out", 64'(P_out), 64'd91902);
      tick();

      // Reset in the middle of a vector.
      A_en = 3'b001; A_in = {16'd0, 16'd0, A_P3513}; P_in = '0;
      tick();
      A_en = 3'b010; A_in = {16'd0, A_P2019, 16'd0};
      tick();
      #2 rst = 1'b1;
      #1;
      checkOutput("midrst_p_out", 64'(P_out), 64'd0);
      checkOutput("midrst_w_loaded", 64'(W_loaded), 64'd0);
      checkOutput("midrst_a_en_out", 64'(A_en_out), 64'd0);
      A_en = '0; A_in = '0;
      @(posedge clk);
      #1 rst = 1'b0;
      A_en = 3'b100; A_in = {A_P2023, 16'd0, 16'd0};
      tick();
      A_en = '0; A_in = '0;
      for (int i = 0; i < 3; i++) begin
         checkOutput("midrst_no_valid", 64'(P_valid_out), 64'd0);
         tick();
      end
      checkOutput("midrst_w_loaded_after", 64'(W_loaded), 64'd0);

      // Overflow boundary on the narrow column.
      W_en2 = 1'b1; W_in2 = 8'h7F;
      tick();
      W_in2 = 8'h00;
      tick();
      W_en2 = 1'b0;
      checkOutput("narrow_w_loaded", 64'(W_loaded2), 64'd1);
      A_en2 = 2'b01; A_in2 = {16'd0, 16'h7FFF}; P_in2 = 24'd8388000;
      tick();
      A_en2 = 2'b10; A_in2 = '0; P_in2 = '0;
      tick();
      A_en2 = '0;
      checkOutput("narrow_valid", 64'(P_valid_out2), 64'd1);
      checkOutput("narrow_overflow_p_out", 64'(P_out2), 64'(SAT_EXP));

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
